// File: rtl/adc_responder.sv
// adc_responder: models the serial side of an 8-channel, 12-bit SAR ADC.
// The initiator's conv edge starts a conversion that stays busy for TCONV_CYCLES.
// While conv is low the result then shifts out on sdo MSB-first, one bit per sck fall.
// The same frame shifts a 6-bit config word in on sdi at sck rises.
// That word selects the channel and mode used by the following conversion.
//
// Ports:
//   clk        - system clock, all flops on its rising edge
//   reset      - synchronous active-high reset
//   conv       - ADC_CONVST from the initiator (asynchronous)
//   sck        - ADC_SCK from the initiator (asynchronous, <= clk/8)
//   sdi        - ADC_SDI config bits (asynchronous)
//   data_in    - eight 12-bit samples, CHn = data_in[12n+11:12n]
//   sdo        - ADC_SDO serial result, registered
//   chan       - channel committed for the next conversion
//   cfg        - last committed config {S/D,O/S,S1,S0,UNI,SLP}
//   frame_done - one-cycle pulse when a frame completes
//   frame_err  - one-cycle pulse on a protocol violation
module adc_responder #(
    parameter int unsigned TCONV_CYCLES = 80,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        conv,
    input  logic        sck,
    input  logic        sdi,
    input  logic [95:0] data_in,
    output logic        sdo,
    output logic [2:0]  chan,
    output logic [5:0]  cfg,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int unsigned TIMER_W = (TCONV_CYCLES > 2) ? $clog2(TCONV_CYCLES) : 1;
    localparam logic [5:0]  CFG_RST = 6'b100000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READY   = 2'd2,
        ST_SHIFT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_conv_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_conv_d;
    logic                   r_sck_d;

    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_bitcnt;
    logic [2:0]         r_rcnt;
    logic [11:0]        r_sample;
    logic [5:0]         r_pend;
    logic [5:0]         r_cfg;
    logic [2:0]         r_chan;
    logic               r_sdo;
    logic               r_done;
    logic               r_err;

    logic w_conv_s;
    logic w_sck_s;
    logic w_sdi_s;
    logic w_conv_rise;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_timer_zero;
    logic [11:0] w_chan_data;

    logic w_start;
    logic w_abort;
    logic w_begin_conv;
    logic w_enter_shift;
    logic w_shift_in;
    logic w_shift_out;
    logic w_complete;
    logic w_early_sck;

    // Synchronizers plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conv_sync <= '0;
            r_sck_sync  <= '0;
            r_sdi_sync  <= '0;
            r_conv_d    <= 1'b0;
            r_sck_d     <= 1'b0;
        end else begin
            r_conv_sync <= SYNC_STAGES'({r_conv_sync, conv});
            r_sck_sync  <= SYNC_STAGES'({r_sck_sync, sck});
            r_sdi_sync  <= SYNC_STAGES'({r_sdi_sync, sdi});
            r_conv_d    <= w_conv_s;
            r_sck_d     <= w_sck_s;
        end
    end

    assign w_conv_s     = r_conv_sync[SYNC_STAGES-1];
    assign w_sck_s      = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi_s      = r_sdi_sync[SYNC_STAGES-1];
    assign w_conv_rise  = w_conv_s & ~r_conv_d;
    assign w_sck_rise   = w_sck_s & ~r_sck_d;
    assign w_sck_fall   = ~w_sck_s & r_sck_d;
    assign w_timer_zero = (r_timer == '0);
    assign w_chan_data  = data_in[7'(r_chan) * 7'd12 +: 12];
    assign w_begin_conv = w_start | w_abort;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a conv rise in READY/SHIFT restarts the conversion
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_conv_rise) w_next = ST_CONVERT;
            ST_CONVERT: if (w_timer_zero) w_next = w_conv_s ? ST_READY : ST_SHIFT;
            ST_READY: begin
                if (w_conv_rise)    w_next = ST_CONVERT;
                else if (!w_conv_s) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_conv_rise)                          w_next = ST_CONVERT;
                else if (w_sck_fall && r_bitcnt == 4'd11) w_next = ST_IDLE;
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes; abort pre-empts any shift activity
    always_comb begin
        w_start       = 1'b0;
        w_abort       = 1'b0;
        w_enter_shift = 1'b0;
        w_shift_in    = 1'b0;
        w_shift_out   = 1'b0;
        w_complete    = 1'b0;
        w_early_sck   = 1'b0;
        case (r_state)
            ST_IDLE:    w_start = w_conv_rise;
            ST_CONVERT: begin
                w_early_sck   = w_sck_rise | w_sck_fall;
                w_enter_shift = w_timer_zero & ~w_conv_s;
            end
            ST_READY: begin
                w_abort       = w_conv_rise;
                w_enter_shift = ~w_conv_s;
            end
            ST_SHIFT: begin
                w_abort     = w_conv_rise;
                w_shift_in  = ~w_conv_rise & w_sck_rise & (r_rcnt < 3'd6);
                w_shift_out = ~w_conv_rise & w_sck_fall;
                w_complete  = ~w_conv_rise & w_sck_fall & (r_bitcnt == 4'd11);
            end
            default: ;
        endcase
    end

    // Datapath: timer, sample capture, serializer, config shift and commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_rcnt   <= '0;
            r_sample <= '0;
            r_pend   <= '0;
            r_cfg    <= CFG_RST;
            r_chan   <= '0;
            r_sdo    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_complete;
            r_err  <= w_abort | w_early_sck;

            if (w_begin_conv) begin
                // Differential mode returns a zero sample
                r_timer  <= TIMER_W'(TCONV_CYCLES - 1);
                r_sample <= r_cfg[5] ? w_chan_data : 12'h000;
                r_pend   <= '0;
                r_sdo    <= 1'b0;
            end else if (r_state == ST_CONVERT && !w_timer_zero) begin
                r_timer <= r_timer - TIMER_W'(1);
            end

            if (w_enter_shift) begin
                r_sdo    <= r_sample[11];
                r_bitcnt <= '0;
                r_rcnt   <= '0;
                r_pend   <= '0;
            end

            // Bits land MSB-first; unreceived LSBs stay zero
            if (w_shift_in) begin
                r_pend[3'd5 - r_rcnt] <= w_sdi_s;
                r_rcnt                <= r_rcnt + 3'd1;
            end

            if (w_shift_out) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                if (w_complete) begin
                    r_sdo  <= 1'b0;
                    r_cfg  <= r_pend;
                    r_chan <= {r_pend[3], r_pend[2], r_pend[4]};
                end else begin
                    r_sdo <= r_sample[4'd10 - r_bitcnt];
                end
            end
        end
    end

    assign sdo        = r_sdo;
    assign chan       = r_chan;
    assign cfg        = r_cfg;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: the stimulus queues expected frame results
// and a monitor checks them whenever frame_done pulses.
module tb_adc_responder;

    localparam int unsigned TCONV = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        conv;
    logic        sck;
    logic        sdi;
    logic [95:0] data_in;
    logic        sdo;
    logic [2:0]  chan;
    logic [5:0]  cfg;
    logic        frame_done;
    logic        frame_err;

    adc_responder #(.TCONV_CYCLES(TCONV), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .conv       (conv),
        .sck        (sck),
        .sdi        (sdi),
        .data_in    (data_in),
        .sdo        (sdo),
        .chan       (chan),
        .cfg        (cfg),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [11:0] data;
        logic [5:0]  cfg;
        logic [2:0]  chan;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_err   = 0;
    logic [11:0] cap_word = '0;
    logic [5:0]  m_cfg;

    // Reference model: channel and sample chosen by a committed config word
    function automatic logic [2:0] m_chan_of(input logic [5:0] c);
        return {c[3], c[2], c[4]};
    endfunction

    function automatic logic [11:0] m_sample(input logic [5:0] c, input logic [95:0] d);
        int ch;
        ch = int'(m_chan_of(c));
        return c[5] ? d[ch*12 +: 12] : 12'h000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pulse counting and scoreboard pop on every completed frame
    always @(negedge clk) begin
        if (frame_done || frame_err)
            check("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
        if (frame_err) n_err++;
        if (frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sdo_word", 32'(cap_word), 32'(mon_e.data));
                check("cfg", 32'(cfg), 32'(mon_e.cfg));
                check("chan", 32'(chan), 32'(mon_e.chan));
            end
        end
    end

    // Conv pulse of 'hold' clocks, optionally re-pulsed mid-conversion, then wait out the busy time
    task automatic do_conv(input int hold, input bit glitch);
        conv = 1'b1;
        tick(hold);
        conv = 1'b0;
        if (hold >= int'(TCONV) + 12) begin
            tick(6);
        end else if (glitch) begin
            tick(26 - hold);
            conv = 1'b1;
            tick(3);
            conv = 1'b0;
            tick(int'(TCONV) + 12 - 29 + 6);
        end else begin
            tick(int'(TCONV) + 12 - hold + 6);
        end
    endtask

    // Initiator serial clocking: sdi set in the low phase, sdo captured late in the high phase
    task automatic shift_bits(input int nfall, input logic [5:0] s, input int half);
        logic [11:0] w;
        w = '0;
        for (int i = 0; i < nfall; i++) begin
            sdi = (i < 6) ? s[5-i] : 1'($urandom);
            tick(half);
            sck = 1'b1;
            tick(half);
            w = {w[10:0], sdo};
            cap_word = w;
            sck = 1'b0;
        end
        tick(8);
    endtask

    task automatic full_frame(input logic [95:0] d, input logic [5:0] s,
                              input int hold, input bit glitch, input int half);
        data_in = d;
        exp_q.push_back('{data: m_sample(m_cfg, d), cfg: s, chan: m_chan_of(s)});
        m_cfg = s;
        do_conv(hold, glitch);
        shift_bits(12, s, half);
        tick(10);
    endtask

    task automatic expect_pulses(input string tag, input int d0, input int e0,
                                 input int dexp, input int eexp);
        check({tag, "_done_cnt"}, 32'(n_done - d0), 32'(dexp));
        check({tag, "_err_cnt"}, 32'(n_err - e0), 32'(eexp));
    endtask

    initial begin
        logic [95:0] d;
        logic [5:0]  s;
        logic [5:0]  old_cfg;
        int          d0;
        int          e0;
        int          hold;

        reset   = 1'b1;
        conv    = 1'b0;
        sck     = 1'b0;
        sdi     = 1'b0;
        data_in = '0;
        m_cfg   = 6'b100000;
        tick(5);
        check("reset_sdo", 32'(sdo), 32'd0);
        check("reset_chan", 32'(chan), 32'd0);
        check("reset_cfg", 32'(cfg), 32'h20);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        tick(5);

        // Basic CH0 frame
        d = {$urandom, $urandom, $urandom};
        d[11:0] = 12'hA5C;
        d0 = n_done; e0 = n_err;
        full_frame(d, 6'b110010, 4, 1'b0, 6);
        expect_pulses("ch0", d0, e0, 1, 0);
        check("ch0_word", 32'(cap_word), 32'hA5C);
        check("ch0_cfg", 32'(cfg), 32'h32);
        check("ch0_chan", 32'(chan), 32'd1);

        // Config committed last frame selects CH1 now; commit differential
        d = {$urandom, $urandom, $urandom};
        d[11:0]  = 12'hFFF;
        d[23:12] = 12'h3F0;
        full_frame(d, 6'b000010, 4, 1'b0, 5);
        check("latency_word", 32'(cap_word), 32'h3F0);

        // Differential returns zero; conv held through busy time (READY path)
        d = {$urandom, $urandom, $urandom};
        full_frame(d, 6'b100000, 100, 1'b0, 4);
        check("diff_word", 32'(cap_word), 32'h000);

        // sck toggled 20 clocks into the conversion: each of the two edges flags an error
        d = {$urandom, $urandom, $urandom};
        s = 6'($urandom);
        d0 = n_done; e0 = n_err;
        data_in = d;
        exp_q.push_back('{data: m_sample(m_cfg, d), cfg: s, chan: m_chan_of(s)});
        m_cfg = s;
        conv = 1'b1;
        tick(4);
        conv = 1'b0;
        tick(16);
        sck = 1'b1;
        tick(6);
        sck = 1'b0;
        tick(int'(TCONV) + 12 - 26 + 6);
        shift_bits(12, s, 5);
        tick(10);
        expect_pulses("early_sck", d0, e0, 1, 2);

        // Abort after 5 falling edges, then the restarted conversion completes
        d = {$urandom, $urandom, $urandom};
        data_in = d;
        d0 = n_done; e0 = n_err;
        do_conv(4, 1'b0);
        shift_bits(5, 6'($urandom), 5);
        old_cfg = m_cfg;
        s = 6'($urandom);
        exp_q.push_back('{data: m_sample(m_cfg, d), cfg: s, chan: m_chan_of(s)});
        m_cfg = s;
        do_conv(4, 1'b0);
        expect_pulses("abort", d0, e0, 0, 1);
        check("abort_chan", 32'(chan), 32'(m_chan_of(old_cfg)));
        check("abort_cfg", 32'(cfg), 32'(old_cfg));
        shift_bits(12, s, 5);
        tick(10);
        expect_pulses("abort_resume", d0, e0, 1, 1);

        // Reset after 7 bits abandons the frame silently
        d = {$urandom, $urandom, $urandom};
        data_in = d;
        d0 = n_done; e0 = n_err;
        do_conv(4, 1'b0);
        shift_bits(7, 6'($urandom), 5);
        reset = 1'b1;
        tick(3);
        check("midreset_sdo", 32'(sdo), 32'd0);
        check("midreset_chan", 32'(chan), 32'd0);
        check("midreset_cfg", 32'(cfg), 32'h20);
        reset = 1'b0;
        m_cfg = 6'b100000;
        tick(4);
        expect_pulses("midreset", d0, e0, 0, 0);
        d = {$urandom, $urandom, $urandom};
        full_frame(d, 6'($urandom), 4, 1'b0, 5);
        check("post_reset_ch0", 32'(cap_word), 32'(d[11:0]));

        // sck activity in IDLE is harmless
        d0 = n_done; e0 = n_err;
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
            tick(5);
        end
        tick(5);
        expect_pulses("idle_sck", d0, e0, 0, 0);

        // Second conv pulse during CONVERT is ignored
        d0 = n_done; e0 = n_err;
        full_frame({$urandom, $urandom, $urandom}, 6'($urandom), 4, 1'b1, 5);
        expect_pulses("conv_in_convert", d0, e0, 1, 0);

        // Randomized frames
        d0 = n_done; e0 = n_err;
        for (int i = 0; i < 20; i++) begin
            hold = ($urandom_range(0, 1) == 1) ? 100 : 4;
            full_frame({$urandom, $urandom, $urandom}, 6'($urandom), hold,
                       (hold == 4) && ($urandom_range(0, 3) == 0),
                       int'($urandom_range(4, 7)));
        end
        expect_pulses("random", d0, e0, 20, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_responder.md
ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 SHALL have parameter TCONV_CYCLES, default 80, meaning the conversion busy time in clk cycles (1.6 us at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on conv, sck and sdi.
REQ-003 clk  input  1  single system clock; every flop SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 conv  input  1  ADC_CONVST from the initiator, asynchronous to clk.
REQ-006 sck  input  1  ADC_SCK from the initiator, asynchronous, at most clk/8.
REQ-007 sdi  input  1  ADC_SDI config bits from the initiator, asynchronous.
REQ-008 data_in  input  96  eight 12-bit channel samples, CHn = data_in[12n+11:12n].
REQ-009 sdo  output  1  ADC_SDO to the initiator, registered.
REQ-010 chan  output  3  channel currently committed for the next conversion.
REQ-011 cfg  output  6  last committed config word {S/D,O/S,S1,S0,UNI,SLP}.
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-013 frame_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-014 conv, sck and sdi SHALL each pass through a SYNC_STAGES flop synchronizer before use.
- Edges SHALL be detected on the synchronized signals, one cycle after the synchronizer output.
REQ-015 The state machine SHALL have four states: IDLE, CONVERT, READY, SHIFT.
REQ-016 IDLE -> CONVERT SHALL occur on a synchronized conv rising edge.
- On that transition, sample = CHchan (12 bits) SHALL be latched.
- The busy timer SHALL be loaded with TCONV_CYCLES-1.
- sdo SHALL be 0.
REQ-017 In CONVERT the timer SHALL decrement once per clk.
- At 0 the state SHALL go to READY.
- Any sck edge seen in CONVERT SHALL pulse frame_err and SHALL otherwise be ignored.
REQ-018 READY -> SHIFT SHALL occur when synchronized conv is low.
- On entry, sdo = sample[11] and the bit counter = 0.
- If conv is already low when the timer expires, CONVERT SHALL go directly to SHIFT.
REQ-019 In SHIFT, on each sck rising edge, while the rising-edge count is below 6, sdi SHALL be shifted MSB-first into a 6-bit pending config register.
REQ-020 In SHIFT, on each sck falling edge, the bit counter SHALL increment.
- While the count after incrementing is below 12, sdo SHALL become sample[11-count].
REQ-021 On the 12th falling edge the block SHALL:
- drive sdo to 0;
- pulse frame_done;
- commit the pending config to cfg;
- go to IDLE.
REQ-022 The channel mapping SHALL be chan = {S1,S0,O/S} from the committed config.
- If S/D = 0 (differential), sample SHALL be forced to 12'h000 for the next conversion.
- UNI and SLP SHALL be stored but SHALL have no functional effect.
REQ-023 A committed config SHALL take effect on the next conversion, not the current one.
REQ-024 A conv rising edge in SHIFT or READY SHALL abort the frame:
- frame_err pulses;
- the pending config is discarded;
- chan/cfg are unchanged;
- CONVERT is entered exactly as from IDLE.
REQ-025 A conv rising edge in CONVERT SHALL be ignored (no restart, no error).
REQ-026 If fewer than 6 rising edges occur before the 12th falling edge, only the bits received SHALL be shifted in, zero-padded at the LSB end.
REQ-027 sck edges in IDLE SHALL be ignored without error.
REQ-028 frame_done and frame_err SHALL never pulse in the same cycle.
- An abort pre-empts completion.

Reset
REQ-029 While reset is high the block SHALL hold:
- state IDLE; sdo = 0;
- chan = 0; cfg = 6'b100000;
- frame_done = 0; frame_err = 0;
- timer, bit counter, sample and pending config all zero;
- synchronizer flops zero.
REQ-030 A reset asserted mid-frame SHALL abandon the frame, with no frame_done or frame_err pulse.
- The first conv rising edge after release SHALL start a fresh conversion on channel 0.

Verification
REQ-031 Frame on CH0: reset, data_in CH0 = 12'hA5C, conv pulse, wait 2 us, 12 sck cycles with sdi = 6'b110010 -> sdo serializes 1010_0101_1100 MSB first, frame_done pulses once, cfg = 6'b110010, chan = 1.
REQ-032 Config latency: after REQ-031, CH1 = 12'h3F0, CH0 = 12'hFFF, next frame -> sdo returns 12'h3F0.
REQ-033 Early sck: sck toggles 20 clk after the conv rise (TCONV_CYCLES = 80) -> frame_err pulses, the state stays CONVERT, and the frame then completes normally.
REQ-034 Abort: conv rises after 5 falling edges -> frame_err pulses once, no frame_done, chan unchanged, new conversion starts.
REQ-035 Differential: commit sdi = 6'b000010 -> the next frame returns 12'h000.
REQ-036 Reset mid-SHIFT after 7 bits -> sdo = 0, chan = 0, no pulses, next frame returns CH0.
